alu_ctrl_sequencer: RTL
=======================

// Module: alu_ctrl_sequencer
// PURPOSE
//  Registered, parametrised ALU control for the multi-cycle MIPS datapath. Decodes {ALUOp, funct} into ALUOperation
//  and adds SLT/ANDI/SLTI/load-store/branch decode. Sequences MULT/DIV through an external iterative unit using
//  start/done handshake, stall, flush and watchdog. Sits between the main control unit and ALU/mult-div unit.
// PARAMETERS
//  ALUOP_W     3    width of ALUOp from main control
//  FUNCT_W     6    width of instruction funct field
//  ALUCTRL_W   4    width of ALUOperation (must be >= 4)
//  TIMEOUT     64   max cycles waiting for mc_done_i before watchdog abort (>= 2)
// PORTS
//  clk            in   1          clock, rising edge
//  reset          in   1          synchronous, active-high
//  valid_i        in   1          ALUOp_i/ALUFunction_i valid this cycle
//  ALUOp_i        in   ALUOP_W    op class from main control
//  ALUFunction_i  in   FUNCT_W    funct field (used only for R-type)
//  flush_i        in   1          kill in-flight multi-cycle op
//  mc_done_i      in   1          iterative MULT/DIV result ready (1-cycle pulse)
//  ALUOperation_o out  ALUCTRL_W  registered ALU operation code
//  op_valid_o     out  1          ALUOperation_o holds a completed/issued op this cycle
//  illegal_o      out  1          decoded combination unsupported (with op_valid_o)
//  mc_start_o     out  1          1-cycle start pulse to mult/div unit
//  mc_abort_o     out  1          1-cycle abort pulse (flush or watchdog)
//  mc_timeout_o   out  1          1-cycle pulse: watchdog expired
//  stall_o        out  1          pipeline hold; inputs ignored while high
// BEHAVIOUR
//  Reset: ALUOperation_o=4'b1001 (NOP), all 1-bit outputs 0, state IDLE, watchdog counter 0.
//  Encodings: AND 0, OR 1, NOR 2, ADD 3, SUB 4, LUI 5, SLL 6, SRL 7, SLT 8, NOP/ILLEGAL 9, MULT A, DIV B.
//  ALUOp: 111 R-type (funct), 100 ADDI->ADD, 001 ORI->OR, 101 LUI->LUI, 010 ANDI->AND, 011 SLTI->SLT,
//   000 LW/SW->ADD, 110 BEQ/BNE->SUB.
//  R funct: 24 AND, 25 OR, 27 NOR, 20 ADD, 22 SUB, 00 SLL, 02 SRL, 2A SLT, 18 MULT, 1A DIV (hex).
//  Anything else -> ALUOperation_o=9, illegal_o=1 with op_valid_o, no start. Upper ALUCTRL_W bits zero.
//  FSM IDLE / ISSUE / WAIT:
//   IDLE, valid_i, single-cycle op: next cycle ALUOperation_o=code, op_valid_o=1 (latency 1); stay IDLE.
//   IDLE, valid_i, MULT/DIV: next cycle ALUOperation_o=A/B, mc_start_o=1, stall_o=1, ->ISSUE; op_valid_o=0.
//   ISSUE: one cycle, ->WAIT; counter cleared; stall_o=1.
//   WAIT: counter +1 per cycle; stall_o=1.
//    mc_done_i -> next cycle op_valid_o=1, stall_o=0, ->IDLE.
//    flush_i (any cycle of ISSUE/WAIT) -> next cycle mc_abort_o=1, stall_o=0, ALUOperation_o=9, ->IDLE.
//    counter==TIMEOUT-1 without done -> next cycle mc_timeout_o=1, mc_abort_o=1, stall_o=0, ALUOperation_o=9, ->IDLE.
//  Priority (same cycle): reset > flush_i > mc_done_i > watchdog.
//  flush_i in IDLE: drops that cycle's valid_i (no output update except op_valid_o=0).
//  mc_done_i outside WAIT: ignored. valid_i while stall_o=1: ignored; upstream holds instruction.
//  Pulses (op_valid_o, mc_start_o, mc_abort_o, mc_timeout_o) are single-cycle registered outputs.
//  ALUOperation_o holds last value until next accepted op/abort; back-to-back single-cycle ops accepted every cycle.
//  Reset mid-WAIT: immediate return to reset state; no abort pulse issued.
// STRUCTURE
//  Package alu_ctrl_pkg: ALUOperation codes, ALUOp class codes, funct codes, state enum {IDLE,ISSUE,WAIT}.
//  Sub-module alu_ctrl_decode: pure combinational {ALUOp,funct} -> {code, is_multicycle, illegal}.
//  Top holds FSM, output registers and $clog2(TIMEOUT)-bit watchdog counter.
// TESTING
//  1) ALUOp=111 funct=20 valid 1 cycle -> next cycle ALUOperation_o=3, op_valid_o=1, stall_o=0.
//  2) Back-to-back ALUOp 100,101,011,110 -> ALUOperation_o 3,5,8,4 on consecutive cycles, op_valid_o high throughout.
//  3) funct=18, mc_done_i 5 cycles after start -> mc_start_o 1 pulse, stall_o high until done+1, op_valid_o=1, code A.
//  4) funct=1A, no done, TIMEOUT=64 -> mc_timeout_o and mc_abort_o pulse after 64 WAIT cycles, ALUOperation_o=9.
//  5) MULT in WAIT, flush_i and mc_done_i same cycle -> mc_abort_o=1, op_valid_o=0, ALUOperation_o=9, IDLE.
//  6) funct=3F R-type -> illegal_o=1, op_valid_o=1, code 9; reset asserted mid-WAIT -> all outputs at reset values.

Source files
------------

// File: rtl/alu_ctrl_sequencer_pkg.sv
// alu_ctrl_pkg
//   Shared constants for the MIPS multi-cycle ALU control sequencer:
//   ALUOperation codes, ALUOp class codes from main control, R-type funct
//   codes and the sequencer state enum.
package alu_ctrl_pkg;

  // ALUOperation codes (4-bit core; wider outputs are zero-extended)
  localparam logic [3:0] OP_AND  = 4'h0;
  localparam logic [3:0] OP_OR   = 4'h1;
  localparam logic [3:0] OP_NOR  = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h4;
  localparam logic [3:0] OP_LUI  = 4'h5;
  localparam logic [3:0] OP_SLL  = 4'h6;
  localparam logic [3:0] OP_SRL  = 4'h7;
  localparam logic [3:0] OP_SLT  = 4'h8;
  localparam logic [3:0] OP_NOP  = 4'h9;
  localparam logic [3:0] OP_MULT = 4'hA;
  localparam logic [3:0] OP_DIV  = 4'hB;

  // ALUOp classes driven by the main control unit
  localparam logic [2:0] ALUOP_LWSW  = 3'b000;
  localparam logic [2:0] ALUOP_ORI   = 3'b001;
  localparam logic [2:0] ALUOP_ANDI  = 3'b010;
  localparam logic [2:0] ALUOP_SLTI  = 3'b011;
  localparam logic [2:0] ALUOP_ADDI  = 3'b100;
  localparam logic [2:0] ALUOP_LUI   = 3'b101;
  localparam logic [2:0] ALUOP_BR    = 3'b110;
  localparam logic [2:0] ALUOP_RTYPE = 3'b111;

  // R-type funct field values
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_MULT = 6'h18;
  localparam logic [5:0] FN_DIV  = 6'h1A;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

endpackage

// File: rtl/alu_ctrl_sequencer_if.sv
// alu_ctrl_sequencer_if
//   Bundles the control-side request, the mult/div handshake and the
//   sequencer results.  Signal suffixes are from the sequencer's viewpoint.
//   master : upstream control / mult-div unit side (drives *_i)
//   slave  : the sequencer (drives *_o)
interface alu_ctrl_sequencer_if #(
  parameter int ALUOP_W   = 3,
  parameter int FUNCT_W   = 6,
  parameter int ALUCTRL_W = 4
);
  logic                 valid_i;
  logic [ALUOP_W-1:0]   ALUOp_i;
  logic [FUNCT_W-1:0]   ALUFunction_i;
  logic                 flush_i;
  logic                 mc_done_i;
  logic [ALUCTRL_W-1:0] ALUOperation_o;
  logic                 op_valid_o;
  logic                 illegal_o;
  logic                 mc_start_o;
  logic                 mc_abort_o;
  logic                 mc_timeout_o;
  logic                 stall_o;

  modport master (
    output valid_i, ALUOp_i, ALUFunction_i, flush_i, mc_done_i,
    input  ALUOperation_o, op_valid_o, illegal_o, mc_start_o,
           mc_abort_o, mc_timeout_o, stall_o
  );

  modport slave (
    input  valid_i, ALUOp_i, ALUFunction_i, flush_i, mc_done_i,
    output ALUOperation_o, op_valid_o, illegal_o, mc_start_o,
           mc_abort_o, mc_timeout_o, stall_o
  );
endinterface

// File: rtl/alu_ctrl_sequencer_decode.sv
// alu_ctrl_decode
//   Purely combinational {ALUOp, funct} decode.
//   aluop_i   : op class from main control
//   funct_i   : funct field, consulted only for R-type
//   code_o    : 4-bit ALUOperation code (NOP on unsupported combinations)
//   is_mc_o   : op needs the iterative mult/div unit
//   illegal_o : combination unsupported
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
#(
  parameter int ALUOP_W = 3,
  parameter int FUNCT_W = 6
) (
  input  logic [ALUOP_W-1:0] aluop_i,
  input  logic [FUNCT_W-1:0] funct_i,
  output logic [3:0]         code_o,
  output logic               is_mc_o,
  output logic               illegal_o
);

  always_comb begin
    code_o    = OP_NOP;
    is_mc_o   = 1'b0;
    illegal_o = 1'b0;
    case (aluop_i)
      ALUOP_W'(ALUOP_ADDI): code_o = OP_ADD;
      ALUOP_W'(ALUOP_ORI):  code_o = OP_OR;
      ALUOP_W'(ALUOP_LUI):  code_o = OP_LUI;
      ALUOP_W'(ALUOP_ANDI): code_o = OP_AND;
      ALUOP_W'(ALUOP_SLTI): code_o = OP_SLT;
      ALUOP_W'(ALUOP_LWSW): code_o = OP_ADD;
      ALUOP_W'(ALUOP_BR):   code_o = OP_SUB;
      ALUOP_W'(ALUOP_RTYPE): begin
        case (funct_i)
          FUNCT_W'(FN_AND):  code_o = OP_AND;
          FUNCT_W'(FN_OR):   code_o = OP_OR;
          FUNCT_W'(FN_NOR):  code_o = OP_NOR;
          FUNCT_W'(FN_ADD):  code_o = OP_ADD;
          FUNCT_W'(FN_SUB):  code_o = OP_SUB;
          FUNCT_W'(FN_SLL):  code_o = OP_SLL;
          FUNCT_W'(FN_SRL):  code_o = OP_SRL;
          FUNCT_W'(FN_SLT):  code_o = OP_SLT;
          FUNCT_W'(FN_MULT): begin code_o = OP_MULT; is_mc_o = 1'b1; end
          FUNCT_W'(FN_DIV):  begin code_o = OP_DIV;  is_mc_o = 1'b1; end
          default:           illegal_o = 1'b1;
        endcase
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_sequencer.sv
// alu_ctrl_sequencer
//   Registered ALU control for the multi-cycle MIPS datapath.  Single-cycle
//   ops appear one cycle after acceptance; MULT/DIV are sequenced through an
//   external iterative unit with start/done, flush and a watchdog.
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : slave side of alu_ctrl_sequencer_if (request, mc handshake,
//           ALUOperation/op_valid/illegal/start/abort/timeout/stall)
module alu_ctrl_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int ALUOP_W   = 3,
  parameter int FUNCT_W   = 6,
  parameter int ALUCTRL_W = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic                clk,
  input  logic                reset,
  alu_ctrl_sequencer_if.slave bus
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [ALUCTRL_W-1:0] NOP_CODE = ALUCTRL_W'(OP_NOP);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ALUCTRL_W-1:0] aluop_q, aluop_d;
  logic                 op_valid_q, op_valid_d;
  logic                 illegal_q, illegal_d;
  logic                 start_q, start_d;
  logic                 abort_q, abort_d;
  logic                 timeout_q, timeout_d;

  logic [3:0] dec_code;
  logic       dec_mc;
  logic       dec_illegal;

  alu_ctrl_decode #(
    .ALUOP_W (ALUOP_W),
    .FUNCT_W (FUNCT_W)
  ) u_decode (
    .aluop_i   (bus.ALUOp_i),
    .funct_i   (bus.ALUFunction_i),
    .code_o    (dec_code),
    .is_mc_o   (dec_mc),
    .illegal_o (dec_illegal)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    aluop_d    = aluop_q;
    op_valid_d = 1'b0;
    illegal_d  = 1'b0;
    start_d    = 1'b0;
    abort_d    = 1'b0;
    timeout_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A flush in IDLE swallows the request without touching the code.
        if (bus.valid_i && !bus.flush_i) begin
          aluop_d = ALUCTRL_W'(dec_code);
          if (dec_mc) begin
            start_d = 1'b1;
            state_d = ISSUE;
          end else begin
            op_valid_d = 1'b1;
            illegal_d  = dec_illegal;
          end
        end
      end
      ISSUE: begin
        cnt_d = '0;
        if (bus.flush_i) begin
          abort_d = 1'b1;
          aluop_d = NOP_CODE;
          state_d = IDLE;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        // flush beats done, done beats the watchdog
        if (bus.flush_i) begin
          abort_d = 1'b1;
          aluop_d = NOP_CODE;
          state_d = IDLE;
        end else if (bus.mc_done_i) begin
          op_valid_d = 1'b1;
          state_d    = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          abort_d   = 1'b1;
          timeout_d = 1'b1;
          aluop_d   = NOP_CODE;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      aluop_q    <= NOP_CODE;
      op_valid_q <= 1'b0;
      illegal_q  <= 1'b0;
      start_q    <= 1'b0;
      abort_q    <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      aluop_q    <= aluop_d;
      op_valid_q <= op_valid_d;
      illegal_q  <= illegal_d;
      start_q    <= start_d;
      abort_q    <= abort_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.ALUOperation_o = aluop_q;
  assign bus.op_valid_o     = op_valid_q;
  assign bus.illegal_o      = illegal_q;
  assign bus.mc_start_o     = start_q;
  assign bus.mc_abort_o     = abort_q;
  assign bus.mc_timeout_o   = timeout_q;
  // Stall is exactly "a multi-cycle op is in flight"; state is registered.
  assign bus.stall_o        = (state_q != IDLE);

endmodule
